uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver; the downstream consumer of the board's serial transmit line, used for loopback testing of the transmitter and for host-to-FPGA input.
- Frame format is 8N1: idle high, one start bit (low), 8 data bits LSB first, one stop bit (high).
- Oversamples the line with the system clock, samples each bit at mid-bit, and presents bytes on a valid/ready holding register.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 256: system clocks per serial bit. Must be ≥ 4; even values are recommended.
- DATA_BITS, 8: data bits per frame. Fixed at 8; the parameter exists for the package constant only.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rxd  in  1  serial input; asynchronous to clk; idle high.
- rx_data  out  8  received byte; valid while rx_valid is high.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts rx_data on a cycle where rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a byte completed while the holding register was full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync-deassert handled externally): FSM=IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, both sync flops=1, previous-sample flop=1, counters=0.
- rxd passes through a 2-flop synchronizer (reset to 1). All decisions below use the synchronized value rs.
- A previous-sample flop holds rs from the prior cycle. A falling edge is prev=1 && rs=0.

FSM states and transitions:
- IDLE: on a falling edge, load the bit counter and go to START; otherwise stay in IDLE. A line held low (break) never triggers a new frame.
- START: wait CLKS_PER_BIT/2 cycles, then sample rs.
  - rs=0: valid start; go to DATA with bit index 0.
  - rs=1: glitch; return to IDLE with no flags raised.
- DATA: every CLKS_PER_BIT cycles, sample rs into shift register position [bit index], LSB first. After the sample at index 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rs, then return to IDLE on the same edge. This leaves half a bit of margin for back-to-back frames.
  - rs=1: complete frame; commit to the holding register (rules below).
  - rs=0: pulse frame_err for one cycle, discard the byte, leave rx_data/rx_valid unchanged.

Holding register:
- Accept occurs when rx_valid && rx_ready. Accept clears rx_valid on the next edge.
- On commit with rx_valid=0, or with an accept in the same cycle: rx_data ← shift register, rx_valid=1 on the next edge, no overrun.
- On commit with rx_valid=1 and no accept: the new byte is dropped, the old rx_data is kept, and overrun pulses for one cycle.
- rx_data is stable whenever rx_valid is high.

Timing and widths:
- Latency from the rxd falling edge to rx_valid rising is 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 clocks (±1 for synchronizer phase).
- The bit counter is $clog2(CLKS_PER_BIT) wide and counts down to 0 with no wrap beyond the load value. The bit index is 3 bits.
- Reset asserted mid-frame aborts immediately. After release the receiver waits for a fresh falling edge.
- rx_ready is ignored when rx_valid=0.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - the DATA_BITS constant;
  - the default CLKS_PER_BIT constant, shared with the transmitter.
- One sub-module, rx_sync: a 2-flop synchronizer with async active-low reset to 1, ports clk, rst_n, d, q.
- The bit timer and FSM stay inline.

Test Plan:
- CLKS_PER_BIT=16, rx_ready=1, send 0x41 in 8N1 → rx_valid pulses one cycle with rx_data=0x41, 155–157 clocks after the start edge; frame_err=0, overrun=0.
- Send 0x00, 0xFF, 0xA5 back-to-back with no idle gap → three accepted bytes in order 0x00, 0xFF, 0xA5; no flags.
- rxd low for 4 clocks, then high → FSM returns to IDLE; no rx_valid, no frame_err; busy high for ≤ 10 clocks.
- Send 0x3C with the stop bit driven low → frame_err pulses once; rx_valid stays 0; no new frame starts until rxd returns high and falls again.
- rx_ready=0, send 0x11 then 0x22 → rx_data=0x11 held with rx_valid=1; overrun pulses at the second stop sample. Raise rx_ready → 0x11 accepted and rx_valid clears.
- Assert rst_n=0 mid-DATA of 0x55, release, send 0x66 → only 0x66 is delivered; all outputs are 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the receiver FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame payload width; the receiver datapath is built around 8-bit bytes.
  localparam int c_DATA_BITS    = 8;

  // Default oversampling ratio, shared with the transmitter.
  localparam int c_CLKS_PER_BIT = 256;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : rx_sync
// Description : Two-flop synchronizer for an idle-high asynchronous input.
//               Both stages reset high so a quiet line never looks like a
//               start-bit edge coming out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  // Two back-to-back flops to resolve metastability on the raw line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 asynchronous serial receiver. Oversamples the line,
//               samples each bit at mid-bit, and hands bytes out through a
//               valid/ready holding register. Framing errors and overruns
//               are reported as single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
  parameter int DATA_BITS    = c_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int                c_CW        = $clog2(CLKS_PER_BIT);
  // Start bit is checked half a bit in, so data bits land at mid-bit.
  localparam logic [c_CW-1:0]   c_HALF_LOAD = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0]   c_FULL_LOAD = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0]   c_ONE       = c_CW'(1);
  localparam logic [2:0]        c_LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 w_rs;
  logic                 r_prev;
  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [c_CW-1:0]      r_cnt;
  logic [c_CW-1:0]      w_cnt_next;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_tick;
  logic                 w_commit;
  logic                 w_stop_bad;
  logic                 w_accept;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (w_rs)
  );

  assign w_tick   = (r_cnt == '0);
  assign w_accept = r_rx_valid && rx_ready;

  // Previous synchronized sample, used for start-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_rs;
    end
  end

  // FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
    end
  end

  // Next-state, timer reload and mid-bit sampling decisions.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_commit       = 1'b0;
    w_stop_bad     = 1'b0;
    case (r_state)
      IDLE: begin
        // Only a high-to-low transition starts a frame; a held-low line does not.
        if (r_prev && !w_rs) begin
          w_state_next = START;
          w_cnt_next   = c_HALF_LOAD;
        end
      end
      START: begin
        if (w_tick) begin
          if (!w_rs) begin
            w_state_next   = DATA;
            w_bit_idx_next = '0;
            w_cnt_next     = c_FULL_LOAD;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - c_ONE;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next[r_bit_idx] = w_rs;
          w_cnt_next              = c_FULL_LOAD;
          if (r_bit_idx == c_LAST_BIT) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt - c_ONE;
        end
      end
      STOP: begin
        // Returning to IDLE at the stop-bit midpoint leaves half a bit of
        // margin to catch a back-to-back start edge.
        if (w_tick) begin
          w_state_next = IDLE;
          if (w_rs) begin
            w_commit = 1'b1;
          end else begin
            w_stop_bad = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - c_ONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Holding register with overrun detection; rx_data never changes while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_commit && r_rx_valid && !w_accept;
      if (w_commit && (!r_rx_valid || w_accept)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx with a frame-level model of
//               the holding register, flags and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rxd      = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observation side
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         ferr_cnt, ovr_cnt, valid_cycles, busy_cycles, busy_run, busy_max;
  int         rise_cyc, ovr_cyc, start_cyc;
  logic       prev_valid = 1'b0;

  // Reference model: frame-level behaviour of the holding register
  logic [7:0] exp_q[$];
  logic       m_valid;
  logic [7:0] m_data;
  int         m_ovr, m_ferr;

  // Monitor sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (rx_valid) valid_cycles++;
      if (frame_err) ferr_cnt++;
      if (overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
      if (busy) begin
        busy_cycles++;
        busy_run++;
        if (busy_run > busy_max) busy_max = busy_run;
      end else begin
        busy_run = 0;
      end
      prev_valid = rx_valid;
    end else begin
      prev_valid = 1'b0;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    ferr_cnt = 0; ovr_cnt = 0; valid_cycles = 0; busy_cycles = 0;
    busy_run = 0; busy_max = 0; rise_cyc = -1; ovr_cyc = -1;
    m_ovr = 0; m_ferr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    idle(CPB);
  endtask

  // Model of one completed frame, applied from the frame's own rules
  task automatic model_frame(input logic [7:0] d, input logic stop_ok);
    if (!stop_ok) m_ferr++;
    else if (rx_ready) exp_q.push_back(d);
    else if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = d;
    end else m_ovr++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
    model_frame(d, stop_bit);
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"},   {24'h0, rx_data}, 32'h0);
    check({tag, "_rx_valid"},  {31'h0, rx_valid}, 32'h0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    check({tag, "_overrun"},   {31'h0, overrun}, 32'h0);
    check({tag, "_busy"},      {31'h0, busy}, 32'h0);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int         glen;
    logic [7:0] rb;
    m_valid = 1'b0;
    m_data  = '0;
    clear_mon();

    // ---- Reset state
    rst_n = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(5);

    // ---- Single byte, latency and one-cycle valid pulse
    clear_mon();
    send_frame(8'h41, 1'b1);
    idle(4);
    compare_queues("single");
    check("single_latency_ok", {31'h0, (rise_cyc - start_cyc >= 155) && (rise_cyc - start_cyc <= 157)}, 32'h1);
    check("single_valid_cycles", valid_cycles, 1);
    check("single_ferr", ferr_cnt, m_ferr);
    check("single_ovr", ovr_cnt, m_ovr);

    // ---- Back-to-back: fixed bytes then random bytes, no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1);
    end
    idle(4);
    compare_queues("b2b");
    check("b2b_ferr", ferr_cnt, 0);
    check("b2b_ovr", ovr_cnt, 0);

    // ---- Glitch shorter than half a bit
    clear_mon();
    glen = int'($urandom_range(1, 5));
    rxd  = 1'b0;
    idle(glen);
    rxd  = 1'b1;
    idle(30);
    check("glitch_valid_cycles", valid_cycles, 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_busy_bounded", {31'h0, (busy_max > 0) && (busy_max <= 10)}, 32'h1);
    check("glitch_busy_now", {31'h0, busy}, 32'h0);

    // ---- Framing error, then line held low (break) must not start a frame
    clear_mon();
    send_frame(8'h3C, 1'b0);
    busy_cycles = 0;
    idle(48);
    check("ferr_count", ferr_cnt, m_ferr);
    check("ferr_no_valid", valid_cycles, 0);
    check("ferr_break_no_busy", busy_cycles, 0);
    rxd = 1'b1;
    idle(CPB);
    rb = 8'($urandom);
    send_frame(rb, 1'b1);
    idle(4);
    compare_queues("ferr_recover");

    // ---- Overrun with rx_ready low
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    check("ovr_valid_held", {31'h0, rx_valid}, {31'h0, m_valid});
    check("ovr_data_held", {24'h0, rx_data}, {24'h0, m_data});
    check("ovr_count", ovr_cnt, m_ovr);
    check("ovr_timing_ok", {31'h0, (ovr_cyc - start_cyc >= 155) && (ovr_cyc - start_cyc <= 157)}, 32'h1);
    check("ovr_ferr", ferr_cnt, 0);
    rx_ready = 1'b1;
    if (m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
    idle(3);
    check("ovr_valid_cleared", {31'h0, rx_valid}, 32'h0);
    compare_queues("ovr_accept");

    // ---- Reset mid-DATA of 0x55, then 0x66 only
    clear_mon();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    idle(5);
    check("midreset_busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    rxd   = 1'b1;
    #2;
    check_all_zero("midreset");
    idle(3);
    rst_n = 1'b1;
    idle(2 * CPB);
    send_frame(8'h66, 1'b1);
    idle(4);
    compare_queues("midreset_after");
    check("midreset_ferr", ferr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
